// File: rtl/clock_time_ctrl.sv
// HH:MM:SS BCD timekeeper with a RUN/SET_HR/SET_MIN/SET_SEC mode sequencer.
// Optional field blinking is enabled by defining CLOCK_SET_BLINK_EN.
module clock_time_ctrl #(
  parameter int unsigned H24 = 1
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       sec_tick,
  input  logic       blink_tick,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [3:0] hr_t,
  output logic [3:0] hr_o,
  output logic [3:0] mn_t,
  output logic [3:0] mn_o,
  output logic [3:0] sc_t,
  output logic [3:0] sc_o,
  output logic [1:0] mode,
  output logic       pm,
  output logic       chime,
  output logic [2:0] blank
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetHr  = 2'd1,
    StSetMin = 2'd2,
    StSetSec = 2'd3
  } mode_e;

  localparam logic [3:0] HrRstT = (H24 != 0) ? 4'd0 : 4'd1;
  localparam logic [3:0] HrRstO = (H24 != 0) ? 4'd0 : 4'd2;

  mode_e      r_mode, w_mode_nxt;
  logic [3:0] r_hr_t, r_hr_o, r_mn_t, r_mn_o, r_sc_t, r_sc_o;
  logic [3:0] w_hr_t_nxt, w_hr_o_nxt, w_mn_t_nxt, w_mn_o_nxt, w_sc_t_nxt, w_sc_o_nxt;
  logic       r_pm, w_pm_nxt;
  logic       r_chime, w_chime_nxt;
  logic [8:0] w_hr_inc;
  logic       w_set_inc;

  // Returns {tens, ones, pm} for the hour one step ahead.
  function automatic logic [8:0] hr_inc(input logic [3:0] t, input logic [3:0] o,
                                        input logic p);
    logic [8:0] r;
    r = {t, o + 4'd1, p};
    if (H24 != 0) begin
      if (t == 4'd2 && o == 4'd3)  r = {4'd0, 4'd0, p};
      else if (o == 4'd9)          r = {t + 4'd1, 4'd0, p};
    end else begin
      if (t == 4'd1 && o == 4'd2)      r = {4'd0, 4'd1, p};
      else if (t == 4'd1 && o == 4'd1) r = {4'd1, 4'd2, ~p};
      else if (o == 4'd9)              r = {4'd1, 4'd0, p};
    end
    return r;
  endfunction

  assign w_hr_inc  = hr_inc(r_hr_t, r_hr_o, r_pm);
  // A mode step in the same cycle swallows key_inc.
  assign w_set_inc = key_inc & ~key_mode;

  always_comb begin
    w_hr_t_nxt  = r_hr_t;
    w_hr_o_nxt  = r_hr_o;
    w_mn_t_nxt  = r_mn_t;
    w_mn_o_nxt  = r_mn_o;
    w_sc_t_nxt  = r_sc_t;
    w_sc_o_nxt  = r_sc_o;
    w_pm_nxt    = r_pm;
    w_mode_nxt  = r_mode;
    w_chime_nxt = 1'b0;
    unique case (r_mode)
      StRun: begin
        if (sec_tick) begin
          if (r_sc_o != 4'd9) begin
            w_sc_o_nxt = r_sc_o + 4'd1;
          end else begin
            w_sc_o_nxt = 4'd0;
            if (r_sc_t != 4'd5) begin
              w_sc_t_nxt = r_sc_t + 4'd1;
            end else begin
              w_sc_t_nxt = 4'd0;
              if (r_mn_o != 4'd9) begin
                w_mn_o_nxt = r_mn_o + 4'd1;
              end else begin
                w_mn_o_nxt = 4'd0;
                if (r_mn_t != 4'd5) begin
                  w_mn_t_nxt = r_mn_t + 4'd1;
                end else begin
                  w_mn_t_nxt = 4'd0;
                  {w_hr_t_nxt, w_hr_o_nxt, w_pm_nxt} = w_hr_inc;
                  w_chime_nxt = 1'b1;
                end
              end
            end
          end
        end
      end
      StSetHr: begin
        if (w_set_inc) {w_hr_t_nxt, w_hr_o_nxt, w_pm_nxt} = w_hr_inc;
      end
      StSetMin: begin
        if (w_set_inc) begin
          if (r_mn_o != 4'd9) begin
            w_mn_o_nxt = r_mn_o + 4'd1;
          end else begin
            w_mn_o_nxt = 4'd0;
            w_mn_t_nxt = (r_mn_t == 4'd5) ? 4'd0 : r_mn_t + 4'd1;
          end
        end
      end
      StSetSec: begin
        if (w_set_inc) begin
          w_sc_t_nxt = 4'd0;
          w_sc_o_nxt = 4'd0;
        end
      end
    endcase
    if (key_mode) begin
      unique case (r_mode)
        StRun:    w_mode_nxt = StSetHr;
        StSetHr:  w_mode_nxt = StSetMin;
        StSetMin: w_mode_nxt = StSetSec;
        StSetSec: w_mode_nxt = StRun;
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      r_mode  <= StRun;
      r_hr_t  <= HrRstT;
      r_hr_o  <= HrRstO;
      r_mn_t  <= 4'd0;
      r_mn_o  <= 4'd0;
      r_sc_t  <= 4'd0;
      r_sc_o  <= 4'd0;
      r_pm    <= 1'b0;
      r_chime <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_hr_t  <= w_hr_t_nxt;
      r_hr_o  <= w_hr_o_nxt;
      r_mn_t  <= w_mn_t_nxt;
      r_mn_o  <= w_mn_o_nxt;
      r_sc_t  <= w_sc_t_nxt;
      r_sc_o  <= w_sc_o_nxt;
      r_pm    <= w_pm_nxt;
      r_chime <= w_chime_nxt;
    end
  end

`ifdef CLOCK_SET_BLINK_EN
  logic       r_phase, w_phase_nxt;
  logic [2:0] r_blank, w_blank_nxt;

  always_comb begin
    w_phase_nxt = r_phase;
    if (key_mode || key_inc)                w_phase_nxt = 1'b0;
    else if (blink_tick && r_mode != StRun) w_phase_nxt = ~r_phase;
    w_blank_nxt = 3'b000;
    unique case (w_mode_nxt)
      StRun:    w_blank_nxt = 3'b000;
      StSetHr:  w_blank_nxt = {w_phase_nxt, 2'b00};
      StSetMin: w_blank_nxt = {1'b0, w_phase_nxt, 1'b0};
      StSetSec: w_blank_nxt = {2'b00, w_phase_nxt};
    endcase
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      r_phase <= 1'b0;
      r_blank <= 3'b000;
    end else begin
      r_phase <= w_phase_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  assign blank = r_blank;
`else
  logic w_unused_blink;
  assign w_unused_blink = blink_tick;
  assign blank          = 3'b000;
`endif

  assign hr_t  = r_hr_t;
  assign hr_o  = r_hr_o;
  assign mn_t  = r_mn_t;
  assign mn_o  = r_mn_o;
  assign sc_t  = r_sc_t;
  assign sc_o  = r_sc_o;
  assign mode  = r_mode;
  assign pm    = r_pm;
  assign chime = r_chime;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: drives a 24-hour and a 12-hour instance with shared stimulus,
// checking both against an integer time model plus a vector table and corner sequences.
module tb_clock_time_ctrl;

  logic CP = 1'b0;
  always #5 CP = ~CP;

  logic CR = 1'b0, sec_tick = 1'b0, blink_tick = 1'b0, key_mode = 1'b0, key_inc = 1'b0;

  logic [3:0] a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o;
  logic [3:0] b_hr_t, b_hr_o, b_mn_t, b_mn_o, b_sc_t, b_sc_o;
  logic [1:0] a_mode, b_mode;
  logic       a_pm, b_pm, a_chime, b_chime;
  logic [2:0] a_blank, b_blank;

  clock_time_ctrl #(.H24(1)) dut24 (
    .CP(CP), .CR(CR), .sec_tick(sec_tick), .blink_tick(blink_tick),
    .key_mode(key_mode), .key_inc(key_inc),
    .hr_t(a_hr_t), .hr_o(a_hr_o), .mn_t(a_mn_t), .mn_o(a_mn_o), .sc_t(a_sc_t), .sc_o(a_sc_o),
    .mode(a_mode), .pm(a_pm), .chime(a_chime), .blank(a_blank)
  );

  clock_time_ctrl #(.H24(0)) dut12 (
    .CP(CP), .CR(CR), .sec_tick(sec_tick), .blink_tick(blink_tick),
    .key_mode(key_mode), .key_inc(key_inc),
    .hr_t(b_hr_t), .hr_o(b_hr_o), .mn_t(b_mn_t), .mn_o(b_mn_o), .sc_t(b_sc_t), .sc_o(b_sc_o),
    .mode(b_mode), .pm(b_pm), .chime(b_chime), .blank(b_blank)
  );

  typedef struct packed {
    logic [3:0] hr_t, hr_o, mn_t, mn_o, sc_t, sc_o;
    logic [1:0] mode;
    logic       pm, chime;
    logic [2:0] blank;
  } obs_t;

  typedef struct packed {
    obs_t e24;
    obs_t e12;
  } exp_t;

  typedef struct {
    logic cr, tk, bl, km, ki;
    int   hms;
    int   md;
  } vec_t;

  obs_t a_obs, b_obs;
  assign a_obs = {a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o, a_mode, a_pm, a_chime, a_blank};
  assign b_obs = {b_hr_t, b_hr_o, b_mn_t, b_mn_o, b_sc_t, b_sc_o, b_mode, b_pm, b_chime, b_blank};

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, in plain integers.
  int   m_h24, m_h12, m_mn, m_sc, m_mode;
  logic m_pm, m_chime, m_phase;
  logic [2:0] m_blank;

  function automatic obs_t mk(input int h, input logic p);
    obs_t o;
    o.hr_t = 4'(h / 10);   o.hr_o = 4'(h % 10);
    o.mn_t = 4'(m_mn / 10); o.mn_o = 4'(m_mn % 10);
    o.sc_t = 4'(m_sc / 10); o.sc_o = 4'(m_sc % 10);
    o.mode = 2'(m_mode);
    o.pm = p; o.chime = m_chime; o.blank = m_blank;
    return o;
  endfunction

  function automatic int hms(input logic [3:0] ht, ho, mt, mo, st, so);
    return ht * 100000 + ho * 10000 + mt * 1000 + mo * 100 + st * 10 + so;
  endfunction

  task automatic model_hr_inc();
    m_h24 = (m_h24 + 1) % 24;
    if (m_h12 == 11) begin
      m_h12 = 12;
      m_pm  = ~m_pm;
    end else if (m_h12 == 12) begin
      m_h12 = 1;
    end else begin
      m_h12 = m_h12 + 1;
    end
  endtask

  task automatic model_update(input logic cr, tk, bl, km, ki);
    int pre;
    pre = m_mode;
    if (cr) begin
      m_h24 = 0; m_h12 = 12; m_pm = 1'b0; m_mn = 0; m_sc = 0;
      m_mode = 0; m_chime = 1'b0; m_phase = 1'b0; m_blank = 3'b000;
    end else begin
      m_chime = 1'b0;
      if (pre == 0 && tk) begin
        m_sc++;
        if (m_sc == 60) begin
          m_sc = 0;
          m_mn++;
          if (m_mn == 60) begin
            m_mn = 0;
            model_hr_inc();
            m_chime = 1'b1;
          end
        end
      end else if (pre == 1 && ki && !km) begin
        model_hr_inc();
      end else if (pre == 2 && ki && !km) begin
        m_mn = (m_mn + 1) % 60;
      end else if (pre == 3 && ki && !km) begin
        m_sc = 0;
      end
      if (km) m_mode = (m_mode + 1) % 4;
      if (km || ki) m_phase = 1'b0;
      else if (bl && pre != 0) m_phase = ~m_phase;
`ifdef CLOCK_SET_BLINK_EN
      m_blank = (m_mode == 1) ? {m_phase, 2'b00} :
                (m_mode == 2) ? {1'b0, m_phase, 1'b0} :
                (m_mode == 3) ? {2'b00, m_phase} : 3'b000;
`else
      m_blank = 3'b000;
`endif
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive, push expectation, then pop and compare after the edge.
  task automatic step(input logic cr, tk, bl, km, ki);
    exp_t e;
    @(negedge CP);
    CR = cr; sec_tick = tk; blink_tick = bl; key_mode = km; key_inc = ki;
    model_update(cr, tk, bl, km, ki);
    sb_q.push_back('{e24: mk(m_h24, 1'b0), e12: mk(m_h12, m_pm)});
    @(posedge CP);
    #1;
    n_checks += 2;
    if (sb_q.size() == 0) begin
      n_fail += 2;
      $display("FAIL scoreboard_empty: got 0 entries required 1");
    end else begin
      e = sb_q.pop_front();
      if (a_obs !== e.e24) begin
        n_fail++;
        $display("FAIL sb_h24 t=%0t: got %h required %h", $time, a_obs, e.e24);
      end
      if (b_obs !== e.e12) begin
        n_fail++;
        $display("FAIL sb_h12 t=%0t: got %h required %h", $time, b_obs, e.e12);
      end
    end
  endtask

  task automatic idle();      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic tick();      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic kmode();     step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic kinc();      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic blink();     step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_reset();  step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  // From reset: s_ticks seconds in RUN, then h_inc hour and m_inc minute presses, back to RUN.
  task automatic preset(input int h_inc, input int m_inc, input int s_ticks);
    do_reset();
    repeat (s_ticks) tick();
    kmode();
    repeat (h_inc) kinc();
    kmode();
    repeat (m_inc) kinc();
    kmode();
    kmode();
  endtask

  task automatic add(input logic cr, tk, bl, km, ki, input int h, input int md);
    tbl.push_back('{cr: cr, tk: tk, bl: bl, km: km, ki: ki, hms: h, md: md});
  endtask

  initial begin
    // cr tk bl km ki | expected 24h hhmmss, mode
    add(1, 0, 0, 0, 0,     0, 0);
    add(0, 1, 0, 0, 0,     1, 0);
    add(0, 1, 0, 0, 0,     2, 0);
    add(0, 0, 0, 1, 0,     2, 1);
    add(0, 0, 0, 0, 1, 10002, 1);
    add(0, 1, 0, 0, 0, 10002, 1);
    add(0, 0, 0, 1, 0, 10002, 2);
    add(0, 0, 0, 0, 1, 10102, 2);
    add(0, 0, 0, 1, 1, 10102, 3);
    add(0, 0, 0, 0, 1, 10100, 3);
    add(0, 0, 0, 1, 0, 10100, 0);
    add(0, 1, 0, 0, 0, 10101, 0);
    add(0, 0, 0, 0, 1, 10101, 0);
    add(0, 1, 0, 1, 0, 10102, 1);

    foreach (tbl[i]) begin
      step(tbl[i].cr, tbl[i].tk, tbl[i].bl, tbl[i].km, tbl[i].ki);
      chk($sformatf("tbl%0d_time", i), hms(a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o),
          tbl[i].hms);
      chk($sformatf("tbl%0d_mode", i), a_mode, tbl[i].md);
    end

    // Reset from 23:59:59
    preset(23, 59, 59);
    chk("preset_235959", hms(a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o), 235959);
    do_reset();
    chk("cr_time", hms(a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o), 0);
    chk("cr_mode", a_mode, 0);
    chk("cr_chime", a_chime, 0);
    chk("cr_blank", a_blank, 0);
    chk("cr_h12_time", hms(b_hr_t, b_hr_o, b_mn_t, b_mn_o, b_sc_t, b_sc_o), 120000);

    // Day rollover with chime
    preset(23, 59, 59);
    tick();
    chk("rollover_time", hms(a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o), 0);
    chk("rollover_chime", a_chime, 1);
    idle();
    chk("chime_one_cycle", a_chime, 0);

    // 12-hour: 11:59:59 -> 12:00:00 pm, then 12:59:59 -> 01:00:00 pm held
    preset(11, 59, 59);
    chk("h12_115959", hms(b_hr_t, b_hr_o, b_mn_t, b_mn_o, b_sc_t, b_sc_o), 115959);
    chk("h12_pm0", b_pm, 0);
    tick();
    chk("h12_noon", hms(b_hr_t, b_hr_o, b_mn_t, b_mn_o, b_sc_t, b_sc_o), 120000);
    chk("h12_pm1", b_pm, 1);
    chk("h24_pm_const", a_pm, 0);
    repeat (59) tick();
    kmode(); kmode();
    repeat (59) kinc();
    kmode(); kmode();
    chk("h12_125959", hms(b_hr_t, b_hr_o, b_mn_t, b_mn_o, b_sc_t, b_sc_o), 125959);
    tick();
    chk("h12_one", hms(b_hr_t, b_hr_o, b_mn_t, b_mn_o, b_sc_t, b_sc_o), 10000);
    chk("h12_pm_kept", b_pm, 1);

    // SET_MIN wrap without hour carry, ticks frozen
    preset(10, 59, 30);
    kmode(); kmode();
    kinc();
    chk("setmin_wrap", hms(a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o), 100030);
    repeat (5) tick();
    chk("set_frozen", hms(a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o), 100030);

    // Simultaneous events
    kmode();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("setsec_exit_mode", a_mode, 0);
    chk("setsec_exit_sec", hms(a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o), 100030);
    kmode();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("km_ki_mode", a_mode, 2);
    chk("km_ki_hour", hms(a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o), 100030);

    // Blink behaviour
    kmode(); kmode();
    blink();
    chk("run_blank", a_blank, 0);
    kmode();
    blink();
`ifdef CLOCK_SET_BLINK_EN
    chk("sethr_blink", a_blank, 3'b100);
`else
    chk("sethr_blink", a_blank, 3'b000);
`endif
    kinc();
    chk("kinc_clears_blank", a_blank, 0);
    blink(); blink();
    chk("blink_toggle_back", a_blank, 0);
    kmode();
    blink();
`ifdef CLOCK_SET_BLINK_EN
    chk("setmin_blink", a_blank, 3'b010);
`else
    chk("setmin_blink", a_blank, 3'b000);
`endif
    do_reset();
    chk("reset_blank", a_blank, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
